// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the ALU-side issue logic and pc_sequencer.
// The master drives the redirect controls; the slave (pc_sequencer) returns fetch state.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             stall;
  logic             branch_en;
  logic             compres;
  logic [WIDTH-1:0] target;
  logic             jump_en;
  logic             call_en;
  logic             ret_en;
  logic             halt_en;
  logic             resume;

  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             flush;
  logic             halted;
  logic [15:0]      taken_count;
  logic             ras_err;

  modport master (
    output stall, branch_en, compres, target, jump_en, call_en, ret_en, halt_en, resume,
    input  pc, pc_valid, flush, halted, taken_count, ras_err
  );

  modport slave (
    input  stall, branch_en, compres, target, jump_en, call_en, ret_en, halt_en, resume,
    output pc, pc_valid, flush, halted, taken_count, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter / branch-resolution stage: picks the next fetch address from ALU results.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_sequencer #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] START_ADDR = '0,
  parameter int unsigned      STEP       = 1,
  parameter int unsigned      RAS_DEPTH  = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  pc_sequencer_if.slave bus
);

  localparam int unsigned      CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic             pc_valid_q, pc_valid_d;
  logic             flush_q, flush_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic             redirect;

  assign pc_inc = pc_q + WIDTH'(STEP);

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned LVL_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_wp_q;
  logic [LVL_W-1:0] ras_lvl_q;
  logic             ras_err_q;
  logic             ras_push, ras_pop, ras_err_set;
  logic             ras_empty, ras_full;
  logic [WIDTH-1:0] ras_top;

  assign ras_empty = (ras_lvl_q == '0);
  assign ras_full  = (ras_lvl_q == LVL_W'(RAS_DEPTH));
  assign ras_top   = ras_mem[ras_wp_q - PTR_W'(1)];

  // Circular stack: when full the write pointer sits on the oldest entry, so a push overwrites it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ras_wp_q  <= '0;
      ras_lvl_q <= '0;
      ras_err_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_mem[PTR_W'(i)] <= '0;
      end
    end else begin
      if (ras_push) begin
        ras_mem[ras_wp_q] <= pc_inc;
        ras_wp_q          <= ras_wp_q + PTR_W'(1);
        if (!ras_full) begin
          ras_lvl_q <= ras_lvl_q + LVL_W'(1);
        end
      end else if (ras_pop) begin
        ras_wp_q  <= ras_wp_q - PTR_W'(1);
        ras_lvl_q <= ras_lvl_q - LVL_W'(1);
      end
      if (ras_err_set) begin
        ras_err_q <= 1'b1;
      end
    end
  end

  assign bus.ras_err = ras_err_q;
`else
  assign bus.ras_err = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= START_ADDR;
      pc_valid_q    <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      flush_q       <= flush_d;
      halted_q      <= halted_d;
      taken_count_q <= taken_count_d;
    end
  end

  // Next-PC selection in priority order: halt, stall, return, call, jump/taken branch, step.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    taken_count_d = taken_count_q;
    redirect      = 1'b0;
    flush_d       = 1'b0;
    pc_valid_d    = 1'b0;
    halted_d      = 1'b0;
`ifdef PC_RAS_EN
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    ras_err_set   = 1'b0;
`endif

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (bus.halt_en) begin
          state_d = ST_HALT;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.ret_en) begin
`ifdef PC_RAS_EN
          if (ras_empty) begin
            pc_d        = pc_inc;
            ras_err_set = 1'b1;
          end else begin
            pc_d     = ras_top;
            ras_pop  = 1'b1;
            redirect = 1'b1;
          end
`else
          pc_d = pc_inc;
`endif
        end else if (bus.call_en) begin
          pc_d     = bus.target;
          redirect = 1'b1;
`ifdef PC_RAS_EN
          ras_push    = 1'b1;
          ras_err_set = ras_full;
`endif
        end else if (bus.jump_en || (bus.branch_en && bus.compres)) begin
          pc_d     = bus.target;
          redirect = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end

      ST_HALT: begin
        if (bus.resume) begin
          state_d = ST_RUN;
          pc_d    = pc_inc;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (redirect && (taken_count_q != CNT_MAX)) begin
      taken_count_d = taken_count_q + CNT_W'(1);
    end
    flush_d    = redirect;
    pc_valid_d = (state_d == ST_RUN);
    halted_d   = (state_d == ST_HALT);
  end

  assign bus.pc          = pc_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.flush       = flush_q;
  assign bus.halted      = halted_q;
  assign bus.taken_count = taken_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam int unsigned W = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  pc_sequencer_if #(.WIDTH(W)) bus ();
  pc_sequencer_if #(.WIDTH(W)) bus2 ();

  pc_sequencer #(.WIDTH(W), .START_ADDR(16'h0000), .STEP(1), .RAS_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  pc_sequencer #(.WIDTH(W), .START_ADDR(16'hFFFE), .STEP(1), .RAS_DEPTH(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [15:0] m_pc;
  logic        m_booted, m_halted, m_flush, m_err;
  logic [15:0] m_count;
  logic [15:0] m_ras[$];

  task automatic idle_inputs();
    bus.stall = 1'b0;  bus.branch_en = 1'b0; bus.compres = 1'b0; bus.target = '0;
    bus.jump_en = 1'b0; bus.call_en = 1'b0; bus.ret_en = 1'b0; bus.halt_en = 1'b0; bus.resume = 1'b0;
    bus2.stall = 1'b0;  bus2.branch_en = 1'b0; bus2.compres = 1'b0; bus2.target = '0;
    bus2.jump_en = 1'b0; bus2.call_en = 1'b0; bus2.ret_en = 1'b0; bus2.halt_en = 1'b0; bus2.resume = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_booted = 1'b0; m_halted = 1'b0; m_flush = 1'b0;
    m_err = 1'b0; m_count = 16'h0000; m_ras.delete();
  endtask

  // Applies the architectural rules to the inputs about to be sampled at the next edge.
  task automatic model_step();
    logic [15:0] inc;
    inc = m_pc + 16'd1;
    m_flush = 1'b0;
    if (!m_booted) begin
      m_booted = 1'b1;
      return;
    end
    if (m_halted) begin
      if (bus.resume) begin
        m_halted = 1'b0;
        m_pc = inc;
      end
      return;
    end
    if (bus.halt_en) begin
      m_halted = 1'b1;
      return;
    end
    if (bus.stall) return;
    if (bus.ret_en) begin
`ifdef PC_RAS_EN
      if (m_ras.size() == 0) begin
        m_pc = inc;
        m_err = 1'b1;
      end else begin
        m_pc = m_ras.pop_back();
        m_flush = 1'b1;
      end
`else
      m_pc = inc;
`endif
    end else if (bus.call_en) begin
`ifdef PC_RAS_EN
      if (m_ras.size() == 4) begin
        void'(m_ras.pop_front());
        m_err = 1'b1;
      end
      m_ras.push_back(inc);
`endif
      m_pc = bus.target;
      m_flush = 1'b1;
    end else if (bus.jump_en || (bus.branch_en && bus.compres)) begin
      m_pc = bus.target;
      m_flush = 1'b1;
    end else begin
      m_pc = inc;
    end
    if (m_flush && m_count != 16'hFFFF) m_count = m_count + 16'd1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.pc, bus.pc_valid, bus.flush, bus.halted, bus.taken_count, bus.ras_err} !==
        {16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values got pc=%h v=%b f=%b h=%b cnt=%h err=%b want pc=0000 v=0 f=0 h=0 cnt=0000 err=0",
               bus.pc, bus.pc_valid, bus.flush, bus.halted, bus.taken_count, bus.ras_err);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({bus.pc, bus.pc_valid, bus.flush} !== {W'(i), 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL boot_seq[%0d] got pc=%h v=%b f=%b want pc=%h v=1 f=0",
                 i, bus.pc, bus.pc_valid, bus.flush, W'(i));
      end
    end
  endtask

  task automatic test_branch();
    bus.branch_en = 1'b1; bus.compres = 1'b1; bus.target = 16'h0040;
    tick();
    vectors++;
    if ({bus.pc, bus.pc_valid, bus.flush, bus.taken_count} !== {16'h0040, 1'b1, 1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL branch_taken got pc=%h v=%b f=%b cnt=%h want pc=0040 v=1 f=1 cnt=0001",
               bus.pc, bus.pc_valid, bus.flush, bus.taken_count);
    end
    idle_inputs();
    tick();
    vectors++;
    if ({bus.pc, bus.flush, bus.taken_count} !== {16'h0041, 1'b0, 16'd1}) begin
      miscompares++;
      $display("FAIL flush_one_cycle got pc=%h f=%b cnt=%h want pc=0041 f=0 cnt=0001",
               bus.pc, bus.flush, bus.taken_count);
    end
    bus.jump_en = 1'b1; bus.target = 16'h0003;
    tick();
    idle_inputs();
    bus.branch_en = 1'b1; bus.compres = 1'b0; bus.target = 16'h0040;
    tick();
    vectors++;
    if ({bus.pc, bus.flush, bus.taken_count} !== {16'h0004, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL branch_not_taken got pc=%h f=%b cnt=%h want pc=0004 f=0 cnt=0002",
               bus.pc, bus.flush, bus.taken_count);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    bus.stall = 1'b1; bus.jump_en = 1'b1; bus.target = 16'h0100;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({bus.pc, bus.flush, bus.taken_count} !== {16'h0004, 1'b0, 16'd2}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got pc=%h f=%b cnt=%h want pc=0004 f=0 cnt=0002",
                 i, bus.pc, bus.flush, bus.taken_count);
      end
    end
    bus.stall = 1'b0;
    tick();
    vectors++;
    if ({bus.pc, bus.flush, bus.taken_count} !== {16'h0100, 1'b1, 16'd3}) begin
      miscompares++;
      $display("FAIL stall_release got pc=%h f=%b cnt=%h want pc=0100 f=1 cnt=0003",
               bus.pc, bus.flush, bus.taken_count);
    end
    idle_inputs();
  endtask

  task automatic test_halt();
    bus.jump_en = 1'b1; bus.target = 16'h0007;
    tick();
    bus.halt_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.halt_en = 1'b0;
      vectors++;
      if ({bus.pc, bus.pc_valid, bus.halted, bus.flush, bus.taken_count} !==
          {16'h0007, 1'b0, 1'b1, 1'b0, 16'd4}) begin
        miscompares++;
        $display("FAIL halt_hold[%0d] got pc=%h v=%b h=%b f=%b cnt=%h want pc=0007 v=0 h=1 f=0 cnt=0004",
                 i, bus.pc, bus.pc_valid, bus.halted, bus.flush, bus.taken_count);
      end
    end
    bus.resume = 1'b1;
    tick();
    vectors++;
    if ({bus.pc, bus.pc_valid, bus.halted, bus.flush, bus.taken_count} !==
        {16'h0008, 1'b1, 1'b0, 1'b0, 16'd4}) begin
      miscompares++;
      $display("FAIL halt_resume got pc=%h v=%b h=%b f=%b cnt=%h want pc=0008 v=1 h=0 f=0 cnt=0004",
               bus.pc, bus.pc_valid, bus.halted, bus.flush, bus.taken_count);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      bus.jump_en = 1'b1; bus.target = 16'h0100 + 16'(i * 16);
      tick();
      vectors++;
      if ({bus.pc, bus.flush, bus.taken_count} !== {16'h0100 + 16'(i * 16), 1'b1, 16'(5 + i)}) begin
        miscompares++;
        $display("FAIL b2b_jump[%0d] got pc=%h f=%b cnt=%h want pc=%h f=1 cnt=%h",
                 i, bus.pc, bus.flush, bus.taken_count, 16'h0100 + 16'(i * 16), 16'(5 + i));
      end
    end
    idle_inputs();
    tick();
    vectors++;
    if ({bus.pc, bus.flush, bus.taken_count} !== {16'h0121, 1'b0, 16'd7}) begin
      miscompares++;
      $display("FAIL b2b_after got pc=%h f=%b cnt=%h want pc=0121 f=0 cnt=0007",
               bus.pc, bus.flush, bus.taken_count);
    end
  endtask

  task automatic test_ras();
    logic [15:0] exp_pc [5];
    do_reset();
    tick();
    bus.jump_en = 1'b1; bus.target = 16'h0010;
    tick();
    idle_inputs();
    bus.call_en = 1'b1; bus.target = 16'h0200;
    tick();
    vectors++;
    if ({bus.pc, bus.flush, bus.taken_count, bus.ras_err} !== {16'h0200, 1'b1, 16'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL call got pc=%h f=%b cnt=%h err=%b want pc=0200 f=1 cnt=0002 err=0",
               bus.pc, bus.flush, bus.taken_count, bus.ras_err);
    end
    idle_inputs();
    bus.ret_en = 1'b1;
    tick();
    idle_inputs();
`ifdef PC_RAS_EN
    vectors++;
    if ({bus.pc, bus.flush, bus.taken_count, bus.ras_err} !== {16'h0011, 1'b1, 16'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL ret got pc=%h f=%b cnt=%h err=%b want pc=0011 f=1 cnt=0003 err=0",
               bus.pc, bus.flush, bus.taken_count, bus.ras_err);
    end
    for (int i = 0; i < 5; i++) begin
      bus.call_en = 1'b1; bus.target = 16'h0300 + 16'(i * 16);
      tick();
      vectors++;
      if ({bus.pc, bus.ras_err} !== {16'h0300 + 16'(i * 16), (i == 4)}) begin
        miscompares++;
        $display("FAIL nested_call[%0d] got pc=%h err=%b want pc=%h err=%b",
                 i, bus.pc, bus.ras_err, 16'h0300 + 16'(i * 16), (i == 4));
      end
    end
    idle_inputs();
    // Oldest return (0012) was overwritten; the fifth pop finds the stack empty.
    exp_pc[0] = 16'h0331; exp_pc[1] = 16'h0321; exp_pc[2] = 16'h0311;
    exp_pc[3] = 16'h0301; exp_pc[4] = 16'h0302;
    for (int i = 0; i < 5; i++) begin
      bus.ret_en = 1'b1;
      tick();
      vectors++;
      if ({bus.pc, bus.flush} !== {exp_pc[i], (i != 4)}) begin
        miscompares++;
        $display("FAIL unwind[%0d] got pc=%h f=%b want pc=%h f=%b",
                 i, bus.pc, bus.flush, exp_pc[i], (i != 4));
      end
    end
    idle_inputs();
    do_reset();
    tick();
    bus.ret_en = 1'b1;
    tick();
    vectors++;
    if ({bus.pc, bus.flush, bus.taken_count, bus.ras_err} !== {16'h0001, 1'b0, 16'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL ret_empty got pc=%h f=%b cnt=%h err=%b want pc=0001 f=0 cnt=0000 err=1",
               bus.pc, bus.flush, bus.taken_count, bus.ras_err);
    end
    idle_inputs();
    bus.call_en = 1'b1; bus.target = 16'h0050;
    tick();
    bus.ret_en = 1'b1; bus.target = 16'h0077;
    tick();
    bus.call_en = 1'b0;
    tick();
    vectors++;
    if ({bus.pc, bus.flush} !== {16'h0003, 1'b0}) begin
      miscompares++;
      $display("FAIL call_ret_same_cycle got pc=%h f=%b want pc=0003 f=0", bus.pc, bus.flush);
    end
    idle_inputs();
`else
    vectors++;
    if ({bus.pc, bus.flush, bus.taken_count, bus.ras_err} !== {16'h0201, 1'b0, 16'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL ret_no_stack got pc=%h f=%b cnt=%h err=%b want pc=0201 f=0 cnt=0002 err=0",
               bus.pc, bus.flush, bus.taken_count, bus.ras_err);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    bus.jump_en = 1'b1; bus.target = 16'h0055;
    tick();
    idle_inputs();
    bus.halt_en = 1'b1;
    tick();
    idle_inputs();
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.pc, bus.pc_valid, bus.flush, bus.halted, bus.taken_count, bus.ras_err} !==
        {16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got pc=%h v=%b f=%b h=%b cnt=%h err=%b want all zero",
               bus.pc, bus.pc_valid, bus.flush, bus.halted, bus.taken_count, bus.ras_err);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.halt_en   = ($urandom_range(0, 19) == 0);
      bus.resume    = ($urandom_range(0, 3) == 0);
      bus.stall     = ($urandom_range(0, 6) == 0);
      bus.branch_en = 1'($urandom_range(0, 1));
      bus.compres   = 1'($urandom_range(0, 1));
      bus.jump_en   = ($urandom_range(0, 5) == 0);
      bus.call_en   = ($urandom_range(0, 4) == 0);
      bus.ret_en    = ($urandom_range(0, 4) == 0);
      bus.target    = 16'($urandom);
      model_step();
      tick();
      vectors++;
      if ({bus.pc, bus.pc_valid, bus.flush, bus.halted, bus.taken_count, bus.ras_err} !==
          {m_pc, (m_booted && !m_halted), m_flush, m_halted, m_count, m_err}) begin
        miscompares++;
        $display("FAIL random[%0d] got pc=%h v=%b f=%b h=%b cnt=%h err=%b want pc=%h v=%b f=%b h=%b cnt=%h err=%b",
                 n, bus.pc, bus.pc_valid, bus.flush, bus.halted, bus.taken_count, bus.ras_err,
                 m_pc, (m_booted && !m_halted), m_flush, m_halted, m_count, m_err);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_saturate();
    logic [15:0] exp_pc [3];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000;
    do_reset();
    vectors++;
    if ({bus2.pc, bus2.pc_valid} !== {16'hFFFE, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_reset got pc=%h v=%b want pc=fffe v=0", bus2.pc, bus2.pc_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus2.pc, bus2.pc_valid, bus2.flush} !== {exp_pc[i], 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL wrap_seq[%0d] got pc=%h v=%b f=%b want pc=%h v=1 f=0",
                 i, bus2.pc, bus2.pc_valid, bus2.flush, exp_pc[i]);
      end
    end
    @(negedge clock);
    force dut2.taken_count_q = 16'hFFFE;
    #1;
    release dut2.taken_count_q;
    bus2.branch_en = 1'b1; bus2.compres = 1'b1; bus2.target = 16'h0010;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({bus2.pc, bus2.flush, bus2.taken_count} !== {16'h0010, 1'b1, 16'hFFFF}) begin
        miscompares++;
        $display("FAIL saturate[%0d] got pc=%h f=%b cnt=%h want pc=0010 f=1 cnt=ffff",
                 i, bus2.pc, bus2.flush, bus2.taken_count);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_branch();
    test_stall();
    test_halt();
    test_back_to_back();
    test_ras();
    test_async_reset();
    test_random();
    test_wrap_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
